tm_tape_window: RTL and testbench
=================================

// Module: tm_tape_window
// PURPOSE
// Tape-side consumer of the head-direction predictor: holds a 3-cell window (L, C, R) around the
// Turing-machine head, serves the current cell and head moves to the TM core, and moves cells to and
// from external tape memory over a req/ack port. Uses pred_r_i/pred_l_i to prefetch the neighbour the
// head is expected to enter, so that predicted moves complete without stalling.
// PARAMETERS
// ADDR_BITS   8   tape address width; head address wraps modulo 2**ADDR_BITS
// CELL_BITS   2   symbol width per tape cell
// STAT_BITS   16  width of the saturating hit/miss counters
// PORTS
// clk          in   1          clock
// rst_n        in   1          synchronous active-low reset
// move_i       in   1          core requests a head move (valid)
// dir_i        in   1          move direction: 1 = right, 0 = left
// move_ready_o out  1          move accepted in any cycle where move_i && move_ready_o
// wr_en_i      in   1          write wr_sym_i into current cell (needs cur_valid_o)
// wr_sym_i     in   CELL_BITS  symbol to write
// cur_valid_o  out  1          C slot valid; cur_sym_o meaningful
// cur_sym_o    out  CELL_BITS  symbol under the head
// head_addr_o  out  ADDR_BITS  tape address of the head
// pred_r_i     in   1          predictor: next move strongly right
// pred_l_i     in   1          predictor: next move strongly left
// mem_req_o    out  1          memory request; addr/we/wdata stable while high
// mem_we_o     out  1          1 = write-back, 0 = read
// mem_addr_o   out  ADDR_BITS  memory address
// mem_wdata_o  out  CELL_BITS  write-back data
// mem_ack_i    in   1          completes request in the cycle it is sampled high with mem_req_o
// mem_rdata_i  in   CELL_BITS  read data, valid in ack cycle
// hits_o       out  STAT_BITS  moves whose target slot was already valid (saturating)
// misses_o     out  STAT_BITS  moves that required a demand fill (saturating)
// BEHAVIOUR
// - Reset (rst_n low at clk edge): head_addr=0; L/C/R valid=0, dirty=0; mem_req_o=0; move_ready_o=0;
//   cur_valid_o=0; cur_sym_o=0; hits/misses=0; FSM=FILL_C. Mid-transaction reset abandons the request
//   (req low next cycle, late ack ignored); dirty cells are lost.
// - FSM states: IDLE, WB (write back evicted dirty cell), FILL_C (demand read of head cell),
//   PREF (prefetch read into L or R). One memory transaction at a time; mem_req_o low >=1 cycle
//   between transactions. Each state leaves on the ack cycle.
// - move_ready_o = (state==IDLE) && cur_valid_o && !wb_pending. Registered outputs, no comb path
//   from move_i to move_ready_o.
// - Write: wr_en_i && cur_valid_o sets C=wr_sym_i, C.dirty=1 at the edge. Write+move same cycle:
//   write applies to old C, then shift (written cell becomes L on right move, R on left move).
//   wr_en_i with cur_valid_o=0 is ignored.
// - Right move accepted: evicted = old L; L<=C, C<=R, R<=invalid; head_addr+1 (wraps 2**ADDR_BITS-1->0).
//   Left move mirrors: evicted = old R; R<=C, C<=L, L<=invalid; head_addr-1 (0 -> all-ones).
//   Target slot valid -> hits+1, cur_valid_o stays 1 (zero-stall). Else misses+1, cur_valid_o=0.
// - Next-state priority from IDLE: (1) evicted cell dirty -> WB, addr = evicted address;
//   (2) C invalid -> FILL_C at head_addr; (3) pred_r_i && !R.valid -> PREF R at head_addr+1;
//   (4) pred_l_i && !L.valid -> PREF L at head_addr-1; else stay IDLE. pred_r_i wins if both high.
// - FILL_C ack: C<=mem_rdata_i, valid=1, dirty=0; cur_valid_o=1 next cycle. PREF ack: slot loaded clean.
//   Prefetch cannot be aborted; moves stall (move_ready_o=0) until it completes.
// - Window is never merged across wrap: with ADDR_BITS such that L and R alias (2**ADDR_BITS<3) the
//   block is unsupported; ADDR_BITS>=2 required.
// - Counters saturate at all-ones; no wrap.
// TESTING
// - Reset then ack every req after 1 cycle, mem[0]=2 -> one read addr 0, cur_sym_o=2, cur_valid_o=1, head=0.
// - pred_r_i=1 in IDLE -> read addr 1 into R; then move right -> hits_o=1, head=1, no stall cycle.
// - No prediction, move left from head 0 -> head=255 (ADDR_BITS=8), misses_o=1, FILL_C read addr 255.
// - wr_en_i+move right same cycle at head 5, then two more right moves -> write-back addr 5 data=wr_sym_i.
// - pred_r_i and pred_l_i both high, neither slot valid -> prefetch addr head+1 first, then head-1.
// - Assert rst_n=0 while mem_req_o high -> mem_req_o=0 next cycle, late ack ignored, refetch addr 0.

Source files
------------

// File: rtl/tm_tape_window.sv
// tm_tape_window: three-cell (L, C, R) window around a Turing-machine head.
// Serves the head cell to the core, accepts head moves, writes back evicted
// dirty cells, and prefetches the predicted neighbour over a req/ack port.
module tm_tape_window #(
  parameter int ADDR_BITS = 8,
  parameter int CELL_BITS = 2,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_i,
  input  logic                 dir_i,
  output logic                 move_ready_o,
  input  logic                 wr_en_i,
  input  logic [CELL_BITS-1:0] wr_sym_i,
  output logic                 cur_valid_o,
  output logic [CELL_BITS-1:0] cur_sym_o,
  output logic [ADDR_BITS-1:0] head_addr_o,
  input  logic                 pred_r_i,
  input  logic                 pred_l_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [CELL_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [CELL_BITS-1:0] mem_rdata_i,
  output logic [STAT_BITS-1:0] hits_o,
  output logic [STAT_BITS-1:0] misses_o
);

  typedef enum logic [1:0] {IDLE, WB, FILL_C, PREF} state_t;

  state_t               state;
  logic                 l_vld, l_dty, c_vld, c_dty, r_vld, r_dty;
  logic [CELL_BITS-1:0] l_sym, c_sym, r_sym;
  logic [ADDR_BITS-1:0] head;
  logic                 pref_r;      // prefetch target: 1 = R slot, 0 = L slot
  logic                 wb_pending;  // evicted dirty cell not yet written back

  logic                 wr_hit;
  logic [CELL_BITS-1:0] c_sym_w;
  logic                 c_dty_w;
  logic                 move_acc;
  logic [ADDR_BITS-1:0] head_p1, head_m1;
  logic                 ev_dirty, tgt_vld;
  logic [CELL_BITS-1:0] ev_sym;
  logic [ADDR_BITS-1:0] ev_addr;

  // The C slot as it looks after this cycle's write, used when it shifts out.
  assign wr_hit   = wr_en_i && c_vld;
  assign c_sym_w  = wr_hit ? wr_sym_i : c_sym;
  assign c_dty_w  = wr_hit | c_dty;
  assign move_acc = move_i && move_ready_o;
  assign head_p1  = head + 1'b1;
  assign head_m1  = head - 1'b1;

  // A right move evicts L and enters R; a left move evicts R and enters L.
  assign ev_dirty = dir_i ? (l_vld && l_dty) : (r_vld && r_dty);
  assign ev_sym   = dir_i ? l_sym : r_sym;
  assign ev_addr  = dir_i ? head_m1 : head_p1;
  assign tgt_vld  = dir_i ? r_vld : l_vld;

  assign cur_valid_o = c_vld;
  assign cur_sym_o   = c_sym;
  assign head_addr_o = head;

  // Window, head and memory-port FSM; all outputs registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FILL_C;
      head         <= '0;
      l_vld        <= 1'b0;  l_dty <= 1'b0;  l_sym <= '0;
      c_vld        <= 1'b0;  c_dty <= 1'b0;  c_sym <= '0;
      r_vld        <= 1'b0;  r_dty <= 1'b0;  r_sym <= '0;
      pref_r       <= 1'b0;
      wb_pending   <= 1'b0;
      move_ready_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      move_ready_o <= 1'b0;
      if (wr_hit) begin
        c_sym <= wr_sym_i;
        c_dty <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (move_acc) begin
            // Shift the window; the written C moves into the trailing slot.
            if (dir_i) begin
              l_vld <= 1'b1;  l_dty <= c_dty_w;  l_sym <= c_sym_w;
              c_vld <= r_vld; c_dty <= r_dty;    c_sym <= r_sym;
              r_vld <= 1'b0;  r_dty <= 1'b0;
              head  <= head_p1;
            end else begin
              r_vld <= 1'b1;  r_dty <= c_dty_w;  r_sym <= c_sym_w;
              c_vld <= l_vld; c_dty <= l_dty;    c_sym <= l_sym;
              l_vld <= 1'b0;  l_dty <= 1'b0;
              head  <= head_m1;
            end
            if (ev_dirty) begin
              wb_pending  <= 1'b1;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= ev_addr;
              mem_wdata_o <= ev_sym;
              state       <= WB;
            end else if (!tgt_vld) begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= dir_i ? head_p1 : head_m1;
              state      <= FILL_C;
            end else begin
              move_ready_o <= !wb_pending;
            end
          end else if (!c_vld) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= head;
            state      <= FILL_C;
          end else if (pred_r_i && !r_vld) begin
            pref_r     <= 1'b1;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= head_p1;
            state      <= PREF;
          end else if (pred_l_i && !l_vld) begin
            pref_r     <= 1'b0;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= head_m1;
            state      <= PREF;
          end else begin
            move_ready_o <= !wb_pending;
          end
        end
        WB: begin
          if (mem_req_o && mem_ack_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            wb_pending <= 1'b0;
            state      <= IDLE;
          end
        end
        FILL_C: begin
          // Entered from reset with the request still low: raise it here.
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= head;
          end else if (mem_ack_i) begin
            c_vld     <= 1'b1;
            c_dty     <= 1'b0;
            c_sym     <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        PREF: begin
          if (mem_req_o && mem_ack_i) begin
            if (pref_r) begin
              r_vld <= 1'b1;  r_dty <= 1'b0;  r_sym <= mem_rdata_i;
            end else begin
              l_vld <= 1'b1;  l_dty <= 1'b0;  l_sym <= mem_rdata_i;
            end
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating hit/miss statistics, one event per accepted move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_o   <= '0;
      misses_o <= '0;
    end else if (move_acc) begin
      if (tgt_vld) begin
        if (hits_o != '1) hits_o <= hits_o + 1'b1;
      end else begin
        if (misses_o != '1) misses_o <= misses_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tm_tape_window.sv
// Bench for tm_tape_window: table of move/write/predict steps with a
// memory-transaction scoreboard, plus a mid-request reset sequence.
module tb_tm_tape_window;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       move_i, dir_i, move_ready_o;
  logic       wr_en_i;
  logic [1:0] wr_sym_i;
  logic       cur_valid_o;
  logic [1:0] cur_sym_o;
  logic [7:0] head_addr_o;
  logic       pred_r_i, pred_l_i;
  logic       mem_req_o, mem_we_o;
  logic [7:0] mem_addr_o;
  logic [1:0] mem_wdata_o;
  logic       mem_ack_i;
  logic [1:0] mem_rdata_i;
  logic [3:0] hits_o, misses_o;

  tm_tape_window #(.ADDR_BITS(8), .CELL_BITS(2), .STAT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .move_i(move_i), .dir_i(dir_i),
    .move_ready_o(move_ready_o), .wr_en_i(wr_en_i), .wr_sym_i(wr_sym_i),
    .cur_valid_o(cur_valid_o), .cur_sym_o(cur_sym_o), .head_addr_o(head_addr_o),
    .pred_r_i(pred_r_i), .pred_l_i(pred_l_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .hits_o(hits_o),
    .misses_o(misses_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction encoding {we, addr, wdata}; reads carry wdata 0.
  function automatic logic [10:0] rd(input logic [7:0] a);
    return {1'b0, a, 2'b00};
  endfunction
  function automatic logic [10:0] wb(input logic [7:0] a, input logic [1:0] d);
    return {1'b1, a, d};
  endfunction

  logic [10:0] sb[$];
  logic [1:0]  mem [256];

  // Memory responder: acks one cycle after it sees a request.
  logic        r_ack = 1'b0;
  logic [1:0]  r_rdata = 2'b0;
  logic        man_ack = 1'b0;
  logic [1:0]  man_rdata = 2'b0;
  logic        resp_en = 1'b1;
  int          wt = 0;
  logic [10:0] cap;
  assign mem_ack_i   = r_ack | man_ack;
  assign mem_rdata_i = man_ack ? man_rdata : r_rdata;

  always @(negedge clk) begin
    if (r_ack) begin
      r_ack = 1'b0;
      wt = 0;
      if (sb.size() == 0) chk("mem txn unexpected", int'(cap), -1);
      else chk("mem txn", int'(cap), int'(sb.pop_front()));
    end else if (resp_en && mem_req_o) begin
      if (wt == 0) wt = 1;
      else begin
        r_ack = 1'b1;
        cap = {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 2'b00};
        r_rdata = mem[mem_addr_o];
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
      end
    end else begin
      wt = 0;
    end
  end

  // Wait until the block sits idle and ready for three cycles.
  task automatic settle(input string nm);
    int good = 0;
    int n = 0;
    while (good < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (move_ready_o && !mem_req_o) good++;
      else good = 0;
    end
    chk({nm, " settle"}, int'(good >= 3), 1);
  endtask

  typedef struct {
    bit mv; bit dir; bit wr; logic [1:0] sym; bit pr; bit pl;
    int ntr; logic [10:0] tr0; logic [10:0] tr1;
    int head; int hits; int misses; int csym; bit cv_after;
  } row_t;

  function automatic row_t mk(input bit mv, dir, wr, input logic [1:0] sym,
                              input bit pr, pl, input int ntr,
                              input logic [10:0] tr0, tr1,
                              input int head, hits, misses, csym, input bit cv);
    row_t r;
    r.mv = mv; r.dir = dir; r.wr = wr; r.sym = sym; r.pr = pr; r.pl = pl;
    r.ntr = ntr; r.tr0 = tr0; r.tr1 = tr1;
    r.head = head; r.hits = hits; r.misses = misses; r.csym = csym; r.cv_after = cv;
    return r;
  endfunction

  row_t tbl[23];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0,0,0,0,1,1,2,rd(1),rd(255),   0, 0,0,2,1);
    tbl[1]  = mk(1,1,0,0,0,0,0,'0,'0,           1, 1,0,1,1);
    tbl[2]  = mk(1,0,0,0,0,0,0,'0,'0,           0, 2,0,2,1);
    tbl[3]  = mk(1,0,0,0,0,0,1,rd(255),'0,    255, 2,1,3,0);
    tbl[4]  = mk(1,1,0,0,0,0,0,'0,'0,           0, 3,1,2,1);
    tbl[5]  = mk(1,1,0,0,0,0,1,rd(1),'0,        1, 3,2,1,0);
    tbl[6]  = mk(0,0,0,0,1,0,1,rd(2),'0,        1, 3,2,1,1);
    tbl[7]  = mk(1,1,0,0,1,0,1,rd(3),'0,        2, 4,2,2,1);
    tbl[8]  = mk(1,1,0,0,1,0,1,rd(4),'0,        3, 5,2,3,1);
    tbl[9]  = mk(1,1,0,0,1,0,1,rd(5),'0,        4, 6,2,0,1);
    tbl[10] = mk(1,1,0,0,1,0,1,rd(6),'0,        5, 7,2,1,1);
    tbl[11] = mk(1,1,1,3,1,0,1,rd(7),'0,        6, 8,2,2,1);
    tbl[12] = mk(1,1,0,0,1,0,2,wb(5,3),rd(8),   7, 9,2,3,1);
    tbl[13] = mk(1,1,0,0,0,0,0,'0,'0,           8,10,2,0,1);
    tbl[14] = mk(0,0,1,1,0,0,0,'0,'0,           8,10,2,1,1);
    tbl[15] = mk(1,0,0,0,0,0,0,'0,'0,           7,11,2,3,1);
    tbl[16] = mk(1,0,0,0,0,0,2,wb(8,1),rd(6),   6,11,3,2,0);
    tbl[17] = mk(1,1,0,0,0,0,0,'0,'0,           7,12,3,3,1);
    tbl[18] = mk(1,0,0,0,0,0,0,'0,'0,           6,13,3,2,1);
    tbl[19] = mk(1,1,0,0,0,0,0,'0,'0,           7,14,3,3,1);
    tbl[20] = mk(1,0,0,0,0,0,0,'0,'0,           6,15,3,2,1);
    tbl[21] = mk(1,1,0,0,0,0,0,'0,'0,           7,15,3,3,1);
    tbl[22] = mk(1,0,0,0,0,0,0,'0,'0,           6,15,3,2,1);

    for (int i = 0; i < 256; i++) mem[i] = 2'(i);
    mem[0] = 2'd2;

    rst_n = 1'b0; move_i = 1'b0; dir_i = 1'b0; wr_en_i = 1'b0; wr_sym_i = 2'd0;
    pred_r_i = 1'b0; pred_l_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset head", int'(head_addr_o), 0);
    chk("reset req", int'(mem_req_o), 0);
    chk("reset ready", int'(move_ready_o), 0);
    chk("reset cur_valid", int'(cur_valid_o), 0);
    chk("reset cur_sym", int'(cur_sym_o), 0);
    chk("reset hits", int'(hits_o), 0);
    chk("reset misses", int'(misses_o), 0);

    sb.push_back(rd(0));
    rst_n = 1'b1;
    settle("initial fill");
    chk("initial cur_sym", int'(cur_sym_o), 2);
    chk("initial cur_valid", int'(cur_valid_o), 1);
    chk("initial head", int'(head_addr_o), 0);
    chk("initial sb empty", sb.size(), 0);

    for (int i = 0; i < 23; i++) begin
      pred_r_i = tbl[i].pr; pred_l_i = tbl[i].pl;
      wr_en_i = tbl[i].wr;  wr_sym_i = tbl[i].sym;
      move_i = tbl[i].mv;   dir_i = tbl[i].dir;
      if (tbl[i].ntr > 0) sb.push_back(tbl[i].tr0);
      if (tbl[i].ntr > 1) sb.push_back(tbl[i].tr1);
      @(posedge clk);
      #1;
      move_i = 1'b0;
      wr_en_i = 1'b0;
      if (tbl[i].mv) chk($sformatf("row%0d cur_valid after move", i), int'(cur_valid_o), int'(tbl[i].cv_after));
      settle($sformatf("row%0d", i));
      chk($sformatf("row%0d head", i), int'(head_addr_o), tbl[i].head);
      chk($sformatf("row%0d hits", i), int'(hits_o), tbl[i].hits);
      chk($sformatf("row%0d misses", i), int'(misses_o), tbl[i].misses);
      chk($sformatf("row%0d cur_sym", i), int'(cur_sym_o), tbl[i].csym);
      chk($sformatf("row%0d sb empty", i), sb.size(), 0);
    end

    // Reset while a fill request is outstanding, with a late ack.
    resp_en = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wr_en_i = 1'b1; wr_sym_i = 2'd3;
    begin
      int n = 0;
      while (!mem_req_o && n < 20) begin @(negedge clk); n++; end
    end
    chk("abort req raised", int'(mem_req_o), 1);
    chk("abort req addr", int'(mem_addr_o), 0);
    @(negedge clk);
    rst_n = 1'b0; man_ack = 1'b1; man_rdata = 2'd1;
    @(negedge clk);
    chk("abort req dropped", int'(mem_req_o), 0);
    chk("abort cur_valid", int'(cur_valid_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late ack ignored", int'(cur_valid_o), 0);
    chk("refetch req", int'(mem_req_o), 1);
    chk("refetch addr", int'(mem_addr_o), 0);
    man_ack = 1'b0;
    wr_en_i = 1'b0;
    sb.push_back(rd(0));
    resp_en = 1'b1;
    settle("refetch");
    chk("refetch cur_sym", int'(cur_sym_o), 2);
    chk("refetch head", int'(head_addr_o), 0);
    chk("refetch hits", int'(hits_o), 0);
    chk("refetch sb empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
